// File: rtl/huffman_encoder_param_if.sv
// Stream bundle for huffman_encoder_param: symbol input and packed-word output.
// Ports: in_valid/in_ready/in_sym (symbol side), out_valid/out_ready/out_data/out_last (word side).
// slave = encoder view, master = producer/consumer view.
interface huffman_encoder_param_if #(
  parameter int SYM_W = 4,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_sym;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport slave (
    input  in_valid, in_sym, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_sym, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/huffman_encoder_param.sv
// Huffman encoder: table-driven variable-length codes packed MSB-first into OUT_W-bit words.
// Ports: clk/rst, bus (symbol + word streams), flush, cfg_* table write, flush_done, err, bits_total.
// Latency: symbol accepted in cycle T reaches out_valid in T+2 at the earliest; stalls hold the word.
module huffman_encoder_param #(
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 8,
  parameter int OUT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  huffman_encoder_param_if.slave bus,
  input  logic                 flush,
  input  logic                 cfg_we,
  input  logic [SYM_W-1:0]     cfg_addr,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [MAX_LEN-1:0]   cfg_code,
  output logic                 flush_done,
  output logic                 err,
  output logic [15:0]          bits_total
);

  localparam int NSYM  = 1 << SYM_W;
  localparam int ACC_W = OUT_W + MAX_LEN;
  localparam int CNT_W = $clog2(ACC_W + 1);

  // RUN: no flush pending. DRAIN: flush pending, full words still leaving.
  // FINAL: waiting for a free output slot to emit the padded tail / done pulse.
  typedef enum logic [1:0] {RUN, DRAIN, FINAL} state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0]   len_tbl  [NSYM];
  logic [MAX_LEN-1:0] code_tbl [NSYM];

  // Accumulator: valid bits occupy the top cnt positions; everything below is kept zero,
  // so the padded tail can be taken straight from the top OUT_W bits.
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [OUT_W-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_last_q;

  logic [LEN_W-1:0]   sym_len;
  logic [MAX_LEN-1:0] sym_code;
  logic               sym_bad;
  logic               word_full;
  logic               slot_free;
  logic               in_ready_c;
  logic               accept;
  logic               extract;
  logic               fin_fire;
  logic [LEN_W-1:0]   pad_sh;
  logic [ACC_W-1:0]   app_bits;
  logic [16:0]        bits_sum;

  // Code table: a write lands at the edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSYM; i++) begin
        len_tbl[i]  <= '0;
        code_tbl[i] <= '0;
      end
    end else if (cfg_we) begin
      len_tbl[cfg_addr]  <= cfg_len;
      code_tbl[cfg_addr] <= cfg_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    sym_len    = len_tbl[bus.in_sym];
    sym_code   = code_tbl[bus.in_sym];
    sym_bad    = (sym_len == '0) || (int'(sym_len) > MAX_LEN);
    word_full  = (cnt >= CNT_W'(OUT_W));
    slot_free  = !out_valid_q || bus.out_ready;
    in_ready_c = (state == RUN) && !word_full;
    accept     = bus.in_valid && in_ready_c;
    // Accept needs cnt < OUT_W and extraction needs cnt >= OUT_W, so they never coincide.
    extract    = word_full && slot_free;
    fin_fire   = (state == FINAL) && slot_free;

    // Park the code in the top MAX_LEN bits, shift its unused high bits off the top so the
    // code is left-aligned, then slide it down past the cnt bits already held.
    pad_sh   = LEN_W'(MAX_LEN) - sym_len;
    app_bits = ({sym_code, {OUT_W{1'b0}}} << pad_sh) >> cnt;

    bits_sum = {1'b0, bits_total} + 17'(sym_len);

    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if (!word_full) state_nxt = FINAL;
      FINAL:   if (slot_free) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Held low during reset so nothing is accepted while the table is being cleared.
  assign bus.in_ready  = in_ready_c && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      flush_done  <= 1'b0;
      err         <= 1'b0;
      bits_total  <= '0;
    end else begin
      flush_done <= 1'b0;

      // Accumulator
      if (accept) begin
        if (sym_bad) begin
          err <= 1'b1;
        end else begin
          acc        <= acc | app_bits;
          cnt        <= cnt + CNT_W'(sym_len);
          bits_total <= bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
        end
      end else if (extract) begin
        acc <= acc << OUT_W;
        cnt <= cnt - CNT_W'(OUT_W);
      end else if (fin_fire) begin
        acc        <= '0;
        cnt        <= '0;
        flush_done <= 1'b1;
      end

      // Output register: loads on a full word or the padded tail, clears on handshake.
      if (extract) begin
        out_data_q  <= acc[ACC_W-1 -: OUT_W];
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
      end else if (fin_fire && (cnt != '0)) begin
        out_data_q  <= acc[ACC_W-1 -: OUT_W];
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_huffman_encoder_param.sv
// Directed bench for huffman_encoder_param with a queue-based word/flush scoreboard.
// Stimulus pushes expected words and flush_done events; a monitor pops them on the DUT side.
module tb_huffman_encoder_param;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [3:0]  cfg_len;
  logic [7:0]  cfg_code;
  logic        flush_done;
  logic        err;
  logic [15:0] bits_total;

  huffman_encoder_param_if #(.SYM_W(4), .OUT_W(8)) bus ();

  huffman_encoder_param #(.SYM_W(4), .MAX_LEN(8), .OUT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_len    (cfg_len),
    .cfg_code   (cfg_code),
    .flush_done (flush_done),
    .err        (err),
    .bits_total (bits_total)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } word_t;

  word_t exp_q [$];
  bit    done_q [$];   // expected out_valid in the flush_done cycle
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    word_t w;
    bit    d;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got 0x%0h last=%0b expected none", bus.out_data, bus.out_last);
        end else begin
          w = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(w.data));
          check("out_last", 32'(bus.out_last), 32'(w.last));
        end
      end
      if (!rst && flush_done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_flush_done: got pulse expected none at %0t", $time);
        end else begin
          d = done_q.pop_front();
          check("flush_done_out_valid", 32'(bus.out_valid), 32'(d));
        end
      end
    end
  end

  task automatic cfg_write(input logic [3:0] a, input logic [3:0] l, input logic [7:0] c);
    cfg_we = 1'b1; cfg_addr = a; cfg_len = l; cfg_code = c;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Offer one symbol; optionally raise flush in the accepting cycle.
  task automatic send_sym(input logic [3:0] s, input bit with_flush);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_sym   = s;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: sym %0d never accepted", s);
    end
    flush = with_flush;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    exp_q.push_back(w);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d words %0d dones outstanding, expected 0", exp_q.size(), done_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   32'(bus.in_ready),  0);
    check({tag, "_out_valid"},  32'(bus.out_valid), 0);
    check({tag, "_out_data"},   32'(bus.out_data),  0);
    check({tag, "_out_last"},   32'(bus.out_last),  0);
    check({tag, "_flush_done"}, 32'(flush_done),    0);
    check({tag, "_err"},        32'(err),           0);
    check({tag, "_bits_total"}, 32'(bits_total),    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_len = '0; cfg_code = '0;
    bus.in_valid = 1'b0; bus.in_sym = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: sym0 = "0", sym1 = "10", sym2 = "110"
    cfg_write(4'd0, 4'd1, 8'b0);
    cfg_write(4'd1, 4'd2, 8'b10);
    cfg_write(4'd2, 4'd3, 8'b110);

    // 10 110 0 0 0 -> 1011_0000 (8 bits)
    push_word(8'hB0, 1'b0);
    send_sym(4'd1, 1'b0); send_sym(4'd2, 1'b0);
    send_sym(4'd0, 1'b0); send_sym(4'd0, 1'b0); send_sym(4'd0, 1'b0);
    wait_idle();
    check("bits_total_after_b0", 32'(bits_total), 8);

    // Backpressure: 8 x "10" = two 0xAA words, second stuck in accumulator
    bus.out_ready = 1'b0;
    push_word(8'hAA, 1'b0);
    push_word(8'hAA, 1'b0);
    for (int i = 0; i < 8; i++) send_sym(4'd1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stall_in_ready", 32'(bus.in_ready), 0);
    check("stall_out_valid", 32'(bus.out_valid), 1);
    check("stall_out_data", 32'(bus.out_data), 32'hAA);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle();
    check("bits_total_after_aa", 32'(bits_total), 24);

    // Flush of a 2-bit tail, then a flush with nothing pending
    send_sym(4'd1, 1'b0);
    push_word(8'h80, 1'b1);
    done_q.push_back(1'b1);
    pulse_flush();
    wait_idle();
    done_q.push_back(1'b0);
    pulse_flush();
    wait_idle();
    check("bits_total_after_flush", 32'(bits_total), 26);

    // Illegal symbol: consumed, sticky err, no bits counted
    send_sym(4'd5, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("err_set", 32'(err), 1);
    check("bits_total_illegal", 32'(bits_total), 26);
    @(posedge clk); #1;
    // 110 110 0 0 -> 1101_1000
    push_word(8'hD8, 1'b0);
    send_sym(4'd2, 1'b0); send_sym(4'd2, 1'b0);
    send_sym(4'd0, 1'b0); send_sym(4'd0, 1'b0);
    wait_idle();
    check("err_sticky", 32'(err), 1);
    check("bits_total_after_d8", 32'(bits_total), 34);

    // Full-length code, then a final symbol accepted together with flush
    cfg_write(4'd15, 4'd8, 8'hA5);
    push_word(8'hA5, 1'b0);
    push_word(8'hA5, 1'b0);
    push_word(8'h00, 1'b1);
    done_q.push_back(1'b1);
    send_sym(4'd15, 1'b0);
    send_sym(4'd15, 1'b0);
    send_sym(4'd0, 1'b1);
    wait_idle();
    check("bits_total_after_a5", 32'(bits_total), 51);

    // Reset with a held word and a partial word in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_sym(4'd1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_out_valid", 32'(bus.out_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check_reset_outputs("midword_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send_sym(4'd1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_reset_err", 32'(err), 1);
    check("post_reset_bits_total", 32'(bits_total), 0);
    check("post_reset_out_valid", 32'(bus.out_valid), 0);
    check("scoreboard_words_left", 32'(exp_q.size()), 0);
    check("scoreboard_dones_left", 32'(done_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
